// File: rtl/sw_pass_scheduler_pkg.sv
// Shared sizing constants and FSM state encoding for the query pass scheduler.
package sw_pass_scheduler_pkg;

  localparam int unsigned PE_N       = 64;
  localparam int unsigned PE_N_LOG   = 6;
  localparam int unsigned S_SIZE_LOG = 12;
  localparam int unsigned VB         = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/sw_pass_scheduler.sv
// Splits a query into PE_N-character passes, sequences S-SRAM fetch and array launch per
// pass, and tracks the running maximum score across passes.
module sw_pass_scheduler
  import sw_pass_scheduler_pkg::*;
#(
  parameter int unsigned PE_N       = sw_pass_scheduler_pkg::PE_N,
  parameter int unsigned PE_N_LOG   = sw_pass_scheduler_pkg::PE_N_LOG,
  parameter int unsigned S_SIZE_LOG = sw_pass_scheduler_pkg::S_SIZE_LOG,
  parameter int unsigned VB         = sw_pass_scheduler_pkg::VB
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [S_SIZE_LOG-1:0]        i_s_size,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [VB-1:0]                o_score,
  output logic                         o_s_rd_en,
  output logic [S_SIZE_LOG-PE_N_LOG-1:0] o_s_rd_addr,
  input  logic [2*PE_N-1:0]            i_s_rd_data,
  output logic                         o_arr_start,
  output logic [2*PE_N-1:0]            o_arr_s,
  output logic [PE_N_LOG-1:0]          o_arr_s_last,
  output logic                         o_arr_first,
  input  logic                         i_arr_valid,
  input  logic [VB-1:0]                i_arr_result
);

  localparam int unsigned PW = S_SIZE_LOG - PE_N_LOG;
  localparam logic [S_SIZE_LOG-1:0] PE_N_W    = S_SIZE_LOG'(PE_N);
  localparam logic [PE_N_LOG-1:0]   LAST_FULL = PE_N_LOG'(PE_N - 1);

  state_e                  state_q, state_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic [S_SIZE_LOG-1:0]   rem_q, rem_d;
  logic [VB-1:0]           max_q, max_d;
  logic [2*PE_N-1:0]       arr_s_q, arr_s_d;
  logic [PE_N_LOG-1:0]     s_last_q, s_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pass_q   <= '0;
      rem_q    <= '0;
      max_q    <= '0;
      arr_s_q  <= '0;
      s_last_q <= '0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      rem_q    <= rem_d;
      max_q    <= max_d;
      arr_s_q  <= arr_s_d;
      s_last_q <= s_last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    rem_d    = rem_q;
    max_d    = max_q;
    arr_s_d  = arr_s_q;
    s_last_d = s_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rem_d   = i_s_size;
          pass_d  = '0;
          max_d   = '0;
          state_d = (i_s_size == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        arr_s_d  = i_s_rd_data;
        // A partial final pass only enables the low rem PEs.
        s_last_d = (rem_q >= PE_N_W) ? LAST_FULL
                                     : (rem_q[PE_N_LOG-1:0] - PE_N_LOG'(1));
        state_d  = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (i_arr_valid) begin
          if (i_arr_result > max_q) max_d = i_arr_result;
          if (rem_q <= PE_N_W) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - PE_N_W;
            pass_d  = pass_q + PW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_score      = max_q;
  assign o_s_rd_en    = (state_q == ST_FETCH);
  assign o_s_rd_addr  = pass_q;
  assign o_arr_start  = (state_q == ST_LAUNCH);
  assign o_arr_s      = arr_s_q;
  assign o_arr_s_last = s_last_q;
  assign o_arr_first  = (pass_q == '0) &&
                        ((state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                         (state_q == ST_LAUNCH) || (state_q == ST_RUN));

endmodule

// File: tb/tb_sw_pass_scheduler.sv
// Scoreboard bench for sw_pass_scheduler: driver queues expected fetch/launch/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sw_pass_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [11:0]  i_s_size = '0;
  logic         o_busy, o_done, o_s_rd_en, o_arr_start, o_arr_first;
  logic [15:0]  o_score;
  logic [5:0]   o_s_rd_addr;
  logic [127:0] i_s_rd_data = '0;
  logic [127:0] o_arr_s;
  logic [5:0]   o_arr_s_last;
  logic         i_arr_valid = 1'b0;
  logic [15:0]  i_arr_result = '0;

  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {logic [5:0] addr; logic first;} rd_t;
  typedef struct {logic [5:0] last; logic first; logic [127:0] s;} launch_t;
  rd_t         exp_rd[$];
  launch_t     exp_launch[$];
  int unsigned exp_done[$];

  sw_pass_scheduler #(.PE_N(64), .PE_N_LOG(6), .S_SIZE_LOG(12), .VB(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_s_size(i_s_size),
    .o_busy(o_busy), .o_done(o_done), .o_score(o_score),
    .o_s_rd_en(o_s_rd_en), .o_s_rd_addr(o_s_rd_addr), .i_s_rd_data(i_s_rd_data),
    .o_arr_start(o_arr_start), .o_arr_s(o_arr_s), .o_arr_s_last(o_arr_s_last),
    .o_arr_first(o_arr_first), .i_arr_valid(i_arr_valid), .i_arr_result(i_arr_result)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] sword(input logic [5:0] a);
    logic [25:0] k;
    k = 26'h2ABCDEF ^ 26'(a);
    return {4{k, a}};
  endfunction

  // S-SRAM model: one-cycle read latency
  always @(posedge clk) if (o_s_rd_en) i_s_rd_data <= sword(o_s_rd_addr);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_s_rd_en) begin
        if (exp_rd.size() == 0) unexpected("rd_en");
        else begin
          rd_t e;
          e = exp_rd.pop_front();
          check("rd_addr", 128'(o_s_rd_addr), 128'(e.addr));
          check("rd_first", 128'(o_arr_first), 128'(e.first));
        end
      end
      if (o_arr_start) begin
        if (exp_launch.size() == 0) unexpected("arr_start");
        else begin
          launch_t e;
          e = exp_launch.pop_front();
          check("s_last", 128'(o_arr_s_last), 128'(e.last));
          check("launch_first", 128'(o_arr_first), 128'(e.first));
          check("arr_s", o_arr_s, e.s);
        end
      end
      if (o_done) begin
        if (exp_done.size() == 0) unexpected("done");
        else check("score", 128'(o_score), 128'(exp_done.pop_front()));
      end
    end
  end

  task automatic push_pass(input int unsigned p, input int unsigned rem);
    rd_t r;
    launch_t l;
    r.addr  = 6'(p);
    r.first = (p == 0);
    l.last  = (rem >= 64) ? 6'd63 : 6'(rem - 1);
    l.first = (p == 0);
    l.s     = sword(6'(p));
    exp_rd.push_back(r);
    exp_launch.push_back(l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(o_busy), 128'(0));
    check({tag, "_done"}, 128'(o_done), 128'(0));
    check({tag, "_score"}, 128'(o_score), 128'(0));
    check({tag, "_rd_en"}, 128'(o_s_rd_en), 128'(0));
    check({tag, "_rd_addr"}, 128'(o_s_rd_addr), 128'(0));
    check({tag, "_start"}, 128'(o_arr_start), 128'(0));
    check({tag, "_arr_s"}, o_arr_s, 128'(0));
    check({tag, "_s_last"}, 128'(o_arr_s_last), 128'(0));
    check({tag, "_first"}, 128'(o_arr_first), 128'(0));
  endtask

  task automatic do_query(input int unsigned size, input int unsigned r0, input int unsigned r1,
                          input int unsigned r2, input bit glitch, input bit abort);
    int unsigned npass, rem, mx, res;
    bit seen;
    npass = (size + 63) / 64;
    rem   = size;
    mx    = 0;
    if (npass == 0) exp_done.push_back(0);
    else push_pass(0, rem);
    @(negedge clk);
    i_start  = 1'b1;
    i_s_size = 12'(size);
    @(negedge clk);
    if (glitch) begin
      i_start      = 1'b1;
      i_s_size     = 12'd5;
      i_arr_valid  = 1'b1;
      i_arr_result = 16'd99;
      @(negedge clk);
      i_arr_valid  = 1'b0;
    end
    i_start  = 1'b0;
    i_s_size = '0;
    for (int unsigned p = 0; p < npass; p++) begin
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        if (o_arr_start) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL launch_timeout: got no arr_start want pass %0d", p);
        return;
      end
      res = (p == 0) ? r0 : (p == 1) ? r1 : r2;
      @(negedge clk);
      if (abort && p == 1) begin
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_hold");
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (res > mx) mx = res;
      if (p == npass - 1) exp_done.push_back(mx);
      else begin
        rem = rem - 64;
        push_pass(p + 1, rem);
      end
      i_arr_valid  = 1'b1;
      i_arr_result = 16'(res);
      @(negedge clk);
      i_arr_valid  = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (o_done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done size %0d", size);
      return;
    end
    @(negedge clk);
    @(negedge clk);
    check("score_hold", 128'(o_score), 128'(mx));
    check("idle_busy", 128'(o_busy), 128'(0));
  endtask

  initial begin
    #1 check_reset_outputs("reset");
    #20 rst_n = 1'b1;
    do_query(0, 0, 0, 0, 1'b0, 1'b0);
    do_query(10, 37, 0, 0, 1'b0, 1'b0);
    do_query(130, 20, 55, 41, 1'b0, 1'b0);
    do_query(128, 12, 80, 0, 1'b0, 1'b0);
    do_query(70, 30, 25, 0, 1'b1, 1'b0);
    do_query(130, 20, 55, 41, 1'b0, 1'b1);
    do_query(10, 5, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rd_q_left", 128'(exp_rd.size()), 128'(0));
    check("launch_q_left", 128'(exp_launch.size()), 128'(0));
    check("done_q_left", 128'(exp_done.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish by time 100000");
    $fatal(1, "watchdog");
  end

endmodule
